// File: rtl/divider.sv
// Sequential restoring shift-subtract divider, one quotient bit per clock.
// Shares the start/finished handshake of the shift-add multiplier.
module divider #(
  parameter int unsigned BITS = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [BITS-1:0] i_dividend,
  input  logic [BITS-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_finished,
  output logic [BITS-1:0] o_quotient,
  output logic [BITS-1:0] o_remainder,
  output logic            o_divide_by_zero
);

  localparam int unsigned CW = $clog2(BITS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [BITS-1:0] quo_q;
  logic [BITS-1:0] div_q;
  logic [BITS:0]   rem_q;
  logic [CW-1:0]   cnt_q;

  logic [BITS+1:0] shifted_rem;
  logic [BITS+1:0] trial;
  logic            borrow;
  logic [BITS:0]   rem_step;
  logic [BITS-1:0] quo_step;
  logic            last_step;

  // One restoring step. The subtraction carries one bit beyond the partial
  // remainder so its MSB is the borrow; the partial remainder's own top bit is
  // always zero after a step, so this matches a BITS+1 trial with borrow out.
  always_comb begin
    shifted_rem = {rem_q, quo_q[BITS-1]};
    trial       = shifted_rem - {2'b00, div_q};
    borrow      = trial[BITS+1];
    rem_step    = borrow ? shifted_rem[BITS:0] : trial[BITS:0];
    quo_step    = {quo_q[BITS-2:0], ~borrow};
    last_step   = (cnt_q == CW'(1));
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (i_start) begin
          state_next = (i_divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    o_busy     = (state != IDLE);
    o_finished = (state == DONE);
  end

  // Working registers and result registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      quo_q            <= '0;
      div_q            <= '0;
      rem_q            <= '0;
      cnt_q            <= '0;
      o_quotient       <= '0;
      o_remainder      <= '0;
      o_divide_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            if (i_divisor != '0) begin
              quo_q <= i_dividend;
              rem_q <= '0;
              div_q <= i_divisor;
              cnt_q <= CW'(BITS);
            end else begin
              o_quotient       <= '1;
              o_remainder      <= i_dividend;
              o_divide_by_zero <= 1'b1;
            end
          end
        end
        RUN: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q - CW'(1);
          if (last_step) begin
            o_quotient       <= quo_step;
            o_remainder      <= rem_step[BITS-1:0];
            o_divide_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/divider.md
Name: divider

Overview:
Sequential restoring shift-subtract divider. It computes quotient = dividend / divisor and remainder = dividend % divisor for unsigned operands, one quotient bit per clock. It is the inverse companion to the team's shift-add multiplier and uses the same start/finished handshake, so both can sit side by side in the arithmetic datapath under one controller.

Parameters:
BITS, 8, operand width; dividend, divisor, quotient and remainder are all BITS wide; BITS >= 2.

Ports:
i_clock  input  1  system clock; all state updates on the rising edge.
i_reset  input  1  asynchronous, active-high reset; clears all state immediately.
i_start  input  1  request to start a division; sampled only in IDLE.
i_dividend  input  BITS  unsigned dividend; captured on the accepted start edge.
i_divisor  input  BITS  unsigned divisor; captured on the accepted start edge.
o_busy  output  1  high in RUN and DONE, low in IDLE.
o_finished  output  1  single-cycle pulse when results become valid.
o_quotient  output  BITS  registered quotient; held until the next completion.
o_remainder  output  BITS  registered remainder; held until the next completion.
o_divide_by_zero  output  1  registered flag; updated with the results and held with them.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state goes to IDLE; any in-flight division is aborted with no o_finished pulse.
  - All outputs go to 0: o_busy, o_finished, o_quotient, o_remainder, o_divide_by_zero.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - Accepted start: i_start=1 at a rising edge.
  - Divisor nonzero: load working quotient register with i_dividend, partial remainder (BITS+1 bits) with 0, divisor register with i_divisor, step counter with BITS. Go to RUN.
  - Divisor zero: go straight to DONE. Register o_quotient = all ones, o_remainder = i_dividend, o_divide_by_zero = 1.
- RUN, each edge:
  - Shift {partial remainder, working quotient} left by 1.
  - Trial = shifted remainder - divisor, computed at BITS+1 width.
  - If trial is non-negative (no borrow): remainder takes trial and quotient LSB = 1. Otherwise keep the shifted remainder and quotient LSB = 0.
  - Decrement the counter.
  - On the edge that performs step BITS (counter 1 -> 0): write the final quotient and the low BITS of the remainder to o_quotient/o_remainder, clear o_divide_by_zero, go to DONE.
- DONE: o_finished=1 for exactly this one cycle; next edge returns to IDLE.
- o_finished is a registered decode of DONE, with no combinational path from inputs.
- Latency, start edge = edge 0:
  - Nonzero divisor: o_finished high in the cycle after edge BITS; BITS+1 cycles start-to-IDLE.
  - Zero divisor: o_finished high in the cycle after edge 0.
- i_start while in RUN or DONE is ignored and not queued. The earliest next accept is the first edge in IDLE.
- i_dividend and i_divisor may change freely after the accepted start edge without affecting the result.
- Result outputs change only on the edge entering DONE. They are stable in IDLE and throughout the next RUN.
- Arithmetic invariant, nonzero divisor: quotient*divisor + remainder == dividend and remainder < divisor.
- The remainder never exceeds BITS bits at completion. The extra trial bit is internal only.

Test Plan:
- BITS=8, pulse start with dividend=200, divisor=7 -> o_busy high from edge 0; o_finished high for exactly 1 cycle after edge 8; quotient=28, remainder=4, divide_by_zero=0.
- Dividend=5, divisor=9 -> quotient=0, remainder=5. Dividend=255, divisor=1 -> 255, 0. Dividend=255, divisor=255 -> 1, 0. Dividend=0, divisor=3 -> 0, 0.
- Dividend=37, divisor=0 -> o_finished 1 cycle after start; quotient=255, remainder=37, divide_by_zero=1. A following 10/3 clears the flag and gives 3, 1.
- Start 100/9, hold i_start high and change inputs to 50/5 during RUN -> exactly one completion with 11, 1. The second request is only taken if i_start is still high in IDLE.
- Start 200/7, assert i_reset asynchronously (between edges) at step 4 -> all outputs 0 immediately, no o_finished. After release, 200/7 completes normally with 28, 4.
- Random sweep of 10,000 operand pairs including 0 and 255 -> invariant holds; o_finished always exactly 8 cycles after a nonzero-divisor start.
